stream_matmul_param: RTL

//  Parametrised streaming signed matrix multiplier: C = A x B, all matrices NxN.

---
 rtl/stream_matmul_param_if.sv | 23 ++
 rtl/stream_matmul_param.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/stream_matmul_param_if.sv
// stream_matmul_param_if: input word stream and result word stream of stream_matmul_param.
// The master modport is the stream fabric side; slave is the multiplier side.
interface stream_matmul_param_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
);
  logic signed [DATA_W-1:0] i_data;
  logic                     i_valid;
  logic                     i_ready;
  logic signed [OUT_W-1:0]  o_data;
  logic                     o_valid;
  logic                     o_ready;

  modport master (
    output i_data, i_valid, o_ready,
    input  i_ready, o_data, o_valid
  );

  modport slave (
    input  i_data, i_valid, o_ready,
    output i_ready, o_data, o_valid
  );
endinterface

// File: rtl/stream_matmul_param.sv
// stream_matmul_param: streaming signed NxN matrix multiply C = A x B over valid/ready words.
// Define MATMUL_SAT_EN to clamp each result to OUT_W; otherwise results wrap to OUT_W bits.
module stream_matmul_param #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
) (
  input logic                  Clk,
  input logic                  rstn,
  stream_matmul_param_if.slave bus
);
  localparam int ACC_W = 2 * DATA_W + $clog2(N);
  localparam int IW    = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

`ifdef MATMUL_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    COMPUTE,
    OUTPUT
  } state_t;

  state_t state;

  logic signed [DATA_W-1:0] a_mem [N][N];
  logic signed [DATA_W-1:0] b_mem [N][N];

  logic [IW-1:0] ld_row, ld_col;
  logic [IW-1:0] row, col, k;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_next;

  logic take;
  logic last_ld;
  logic last_el;

  function automatic logic signed [OUT_W-1:0] reduce(input logic signed [ACC_W-1:0] v);
`ifdef MATMUL_SAT_EN
    if (v > SAT_MAX) begin
      return SAT_MAX[OUT_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[OUT_W-1:0];
    end else begin
      return v[OUT_W-1:0];
    end
`else
    return v[OUT_W-1:0];
`endif
  endfunction

  always_comb begin
    take    = bus.i_valid && bus.i_ready;
    last_ld = (ld_row == LAST) && (ld_col == LAST);
    last_el = (row == LAST) && (col == LAST);
    // Operands are widened first so the product is formed exactly at accumulator width.
    prod     = ACC_W'(a_mem[row][k]) * ACC_W'(b_mem[k][col]);
    acc_next = ((k == '0) ? '0 : acc) + prod;
  end

  // Operand storage carries no reset: a fresh frame always overwrites every entry before use.
  always_ff @(posedge Clk) begin
    if (take && state == LOAD_A) begin
      a_mem[ld_row][ld_col] <= bus.i_data;
    end
    if (take && state == LOAD_B) begin
      b_mem[ld_row][ld_col] <= bus.i_data;
    end
  end

  always_ff @(posedge Clk or negedge rstn) begin
    if (!rstn) begin
      state       <= LOAD_A;
      ld_row      <= '0;
      ld_col      <= '0;
      row         <= '0;
      col         <= '0;
      k           <= '0;
      acc         <= '0;
      bus.i_ready <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
    end else begin
      case (state)
        LOAD_A, LOAD_B: begin
          bus.i_ready <= 1'b1;
          if (take) begin
            if (last_ld) begin
              ld_row <= '0;
              ld_col <= '0;
              if (state == LOAD_A) begin
                state <= LOAD_B;
              end else begin
                state       <= COMPUTE;
                bus.i_ready <= 1'b0;
                row         <= '0;
                col         <= '0;
                k           <= '0;
              end
            end else if (ld_col == LAST) begin
              ld_col <= '0;
              ld_row <= ld_row + IW'(1);
            end else begin
              ld_col <= ld_col + IW'(1);
            end
          end
        end

        COMPUTE: begin
          acc <= acc_next;
          if (k == LAST) begin
            k           <= '0;
            bus.o_data  <= reduce(acc_next);
            bus.o_valid <= 1'b1;
            state       <= OUTPUT;
          end else begin
            k <= k + IW'(1);
          end
        end

        OUTPUT: begin
          if (bus.o_valid && bus.o_ready) begin
            bus.o_valid <= 1'b0;
            if (last_el) begin
              row         <= '0;
              col         <= '0;
              state       <= LOAD_A;
              bus.i_ready <= 1'b1;
            end else begin
              state <= COMPUTE;
              if (col == LAST) begin
                col <= '0;
                row <= row + IW'(1);
              end else begin
                col <= col + IW'(1);
              end
            end
          end
        end

        default: state <= LOAD_A;
      endcase
    end
  end
endmodule
